// File: rtl/pifdefs.sv
// Shared definitions for the I2C-fed register sequencer: byte tags, register
// map, reset values and the FSM state encoding.
package pifdefs;

  localparam int I2C_DATA_BITS = 6;

  typedef logic [I2C_DATA_BITS-1:0] pif_data_t;

  localparam logic [1:0] TAG_ADDR = 2'b00;
  localparam logic [1:0] TAG_DATA = 2'b01;

  localparam pif_data_t ADDR_ID       = 6'd0;
  localparam pif_data_t ADDR_SCRATCH  = 6'd1;
  localparam pif_data_t ADDR_LED_CTRL = 6'd2;
  localparam pif_data_t ADDR_HALF_PER = 6'd3;

  localparam pif_data_t RST_LED_CTRL = 6'h02;
  localparam pif_data_t RST_HALF_PER = 6'd19;

  localparam int LED_SYNC_BIT = 0;
  localparam int LED_EN_BIT   = 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ERROR  = 2'd2
  } pif_state_t;

  // Only pointer values 0..7 map onto the physical register file.
  function automatic logic in_regfile(input pif_data_t addr);
    return addr[I2C_DATA_BITS-1:3] == 3'b000;
  endfunction

endpackage

// File: rtl/pif_reg_seq_if.sv
// Byte-stream handshake between the I2C slave core (master side) and the
// register sequencer (slave side).
interface pif_reg_seq_if;

  logic       rx_valid;
  logic [7:0] rx_byte;
  logic       rx_stop;
  logic       tx_req;
  logic       tx_valid;
  logic [7:0] tx_byte;

  modport master (
    output rx_valid, rx_byte, rx_stop, tx_req,
    input  tx_valid, tx_byte
  );

  modport slave (
    input  rx_valid, rx_byte, rx_stop, tx_req,
    output tx_valid, tx_byte
  );

endinterface

// File: rtl/pif_blink.sv
// LED blinker: prescaler tick, programmable half-period counter and the
// enable/sync/alternate output mux.
module pif_blink
  import pifdefs::*;
#(
  parameter int PRESCALE = 1000
) (
  input  logic      clk,
  input  logic      GSRn,
  input  logic      restart,
  input  logic      led_sync,
  input  logic      led_en,
  input  pif_data_t half_period,
  output logic      LEDR,
  output logic      LEDG
);

  localparam int PW = $clog2(PRESCALE);

  logic [PW-1:0] pre_cnt;
  pif_data_t     half_cnt;
  logic          phase;
  logic          tick;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!GSRn) begin
      pre_cnt  <= '0;
      half_cnt <= '0;
      phase    <= 1'b0;
    end else if (restart) begin
      pre_cnt  <= '0;
      half_cnt <= '0;
      phase    <= 1'b0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + PW'(1);
      if (tick) begin
        if (half_cnt == half_period) begin
          half_cnt <= '0;
          phase    <= ~phase;
        end else begin
          half_cnt <= half_cnt + 6'd1;
        end
      end
    end
  end

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    LEDR = 1'b0;
    LEDG = 1'b0;
    if (led_en) begin
      LEDR = phase;
      LEDG = led_sync ? phase : ~phase;
    end
  end

endmodule

// File: rtl/pif_reg_seq.sv
// Register sequencer behind an I2C slave: tagged bytes load a pointer or write
// registers, read requests stream registers back, and reg2/reg3 drive a blinker.
module pif_reg_seq
  import pifdefs::*;
#(
  parameter int        PRESCALE = 1000,
  parameter pif_data_t ID_VALUE = 6'h2A
) (
  input  logic          clk,
  input  logic          GSRn,
  pif_reg_seq_if.slave  pif,
  output logic          err,
  output logic          LEDR,
  output logic          LEDG
);

  pif_state_t state;
  pif_state_t state_rx;
  pif_data_t  ptr;
  pif_data_t  ptr_rx;
  pif_data_t  pend_addr;
  pif_data_t  rd_addr;
  pif_data_t  rd_data;
  pif_data_t  regs [1:7];
  logic       pending;
  logic       wr_en;
  logic       wr_ok;
  logic       err_set;
  logic       rd_go;
  logic       rd_defer;
  logic       rd_drop;
  logic       blink_restart;

  logic [1:0] tag;
  pif_data_t  payload;

  assign tag     = pif.rx_byte[7:6];
  assign payload = pif.rx_byte[I2C_DATA_BITS-1:0];

  // Effect of the received byte on state and pointer; rx_stop overrides the
  // state only after the byte itself has been interpreted.
  always_comb begin
    state_rx = state;
    ptr_rx   = ptr;
    wr_en    = 1'b0;
    err_set  = 1'b0;
    if (pif.rx_valid) begin
      case (state)
        IDLE: begin
          if (tag == TAG_ADDR) begin
            ptr_rx   = payload;
            state_rx = ACTIVE;
          end else if (tag == TAG_DATA) begin
            err_set  = 1'b1;
            state_rx = ERROR;
          end
        end
        ACTIVE: begin
          if (tag == TAG_ADDR) begin
            ptr_rx = payload;
          end else if (tag == TAG_DATA) begin
            wr_en  = 1'b1;
            ptr_rx = ptr + 6'd1;
          end
        end
        default: ;
      endcase
    end
    if (pif.rx_stop) state_rx = IDLE;
  end

  assign wr_ok = wr_en && in_regfile(ptr) && (ptr != ADDR_ID);

  // A read colliding with an rx byte is parked with the pointer it saw, then
  // served one cycle later so it returns the freshly written contents.
  assign rd_defer = pif.tx_req && !pending && pif.rx_valid;
  assign rd_drop  = pif.tx_req && pending;
  assign rd_go    = pending || (pif.tx_req && !pif.rx_valid);
  assign rd_addr  = pending ? pend_addr : ptr;

  always_comb begin
    rd_data = '0;
    if (in_regfile(rd_addr)) begin
      if (rd_addr[2:0] == 3'd0) rd_data = ID_VALUE;
      else                      rd_data = regs[rd_addr[2:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!GSRn) begin
      state         <= IDLE;
      ptr           <= '0;
      pend_addr     <= '0;
      pending       <= 1'b0;
      err           <= 1'b0;
      pif.tx_valid  <= 1'b0;
      pif.tx_byte   <= '0;
      blink_restart <= 1'b0;
      // NOTE: this register file is small and its power-up contents are
      // architecturally visible, so it is reset like ordinary flops.
      for (int i = 1; i <= 7; i++) regs[i] <= '0;
      regs[ADDR_LED_CTRL[2:0]] <= RST_LED_CTRL;
      regs[ADDR_HALF_PER[2:0]] <= RST_HALF_PER;
    end else begin
      state         <= state_rx;
      ptr           <= rd_go ? ptr_rx + 6'd1 : ptr_rx;
      pending       <= rd_defer;
      pif.tx_valid  <= rd_go;
      blink_restart <= wr_ok && (ptr == ADDR_LED_CTRL || ptr == ADDR_HALF_PER);
      if (rd_defer)          pend_addr   <= ptr;
      if (rd_go)             pif.tx_byte <= {TAG_DATA, rd_data};
      if (wr_ok)             regs[ptr[2:0]] <= payload;
      if (err_set || rd_drop) err        <= 1'b1;
    end
  end

  pif_blink #(
    .PRESCALE (PRESCALE)
  ) u_blink (
    .clk         (clk),
    .GSRn        (GSRn),
    .restart     (blink_restart),
    .led_sync    (regs[ADDR_LED_CTRL[2:0]][LED_SYNC_BIT]),
    .led_en      (regs[ADDR_LED_CTRL[2:0]][LED_EN_BIT]),
    .half_period (regs[ADDR_HALF_PER[2:0]]),
    .LEDR        (LEDR),
    .LEDG        (LEDG)
  );

endmodule

// File: tb/tb_pif_reg_seq.sv
// Directed bench for pif_reg_seq: stimulus pushes expected read bytes into a
// scoreboard queue, a monitor pops them whenever tx_valid is seen.
module tb_pif_reg_seq;

  logic clk;
  logic GSRn;
  logic err;
  logic LEDR;
  logic LEDG;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic [7:0] data;
    int         due;
  } exp_t;

  exp_t sb_q[$];

  pif_reg_seq_if pif ();

  pif_reg_seq #(
    .PRESCALE (4),
    .ID_VALUE (6'h2A)
  ) dut (
    .clk  (clk),
    .GSRn (GSRn),
    .pif  (pif),
    .err  (err),
    .LEDR (LEDR),
    .LEDG (LEDG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every tx strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (pif.tx_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected actual=%0h expected=none", pif.tx_byte);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("tx_byte", 32'(pif.tx_byte), 32'(e.data));
        check("tx_cycle", 32'(cyc), 32'(e.due));
      end
    end
  end

  task automatic step(input logic rv, input logic [7:0] rb, input logic rs, input logic tr);
    pif.rx_valid = rv;
    pif.rx_byte  = rb;
    pif.rx_stop  = rs;
    pif.tx_req   = tr;
    @(negedge clk);
    pif.rx_valid = 1'b0;
    pif.rx_byte  = 8'h00;
    pif.rx_stop  = 1'b0;
    pif.tx_req   = 1'b0;
  endtask

  task automatic rx(input logic [7:0] b);
    step(1'b1, b, 1'b0, 1'b0);
  endtask

  task automatic stop();
    step(1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic rd(input logic [7:0] exp);
    sb_q.push_back('{data: exp, due: cyc + 1});
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic rx_rd(input logic [7:0] b, input logic [7:0] exp);
    sb_q.push_back('{data: exp, due: cyc + 2});
    step(1'b1, b, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_toggle(output int n);
    logic prev;
    prev = LEDR;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (LEDR !== prev) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    checks   = 0;
    failures = 0;
    GSRn         = 1'b0;
    pif.rx_valid = 1'b0;
    pif.rx_byte  = 8'h00;
    pif.rx_stop  = 1'b0;
    pif.tx_req   = 1'b0;
    idle(3);
    GSRn = 1'b1;
    idle(1);

    // Reset state: LEDs enabled, alternate, phase 0.
    check("rst_err", 32'(err), 0);
    check("rst_tx_valid", 32'(pif.tx_valid), 0);
    check("rst_tx_byte", 32'(pif.tx_byte), 0);
    check("rst_ledr", 32'(LEDR), 0);
    check("rst_ledg", 32'(LEDG), 1);

    // reg2 = 1: LEDs disabled.
    rx(8'h02); rx(8'h41); stop();
    idle(2);
    check("dis_err", 32'(err), 0);
    check("dis_ledr", 32'(LEDR), 0);
    check("dis_ledg", 32'(LEDG), 0);

    // reg1 scratch = 0x15.
    rx(8'h01); rx(8'h55);

    // Sync blinking, reg3 = 0: toggle every 4 clocks.
    rx(8'h02); rx(8'h43); rx(8'h40);
    wait_toggle(n);
    check("sync_toggle_seen", 32'(n != 0), 1);
    check("sync_same", 32'(LEDR == LEDG), 1);
    wait_toggle(n);
    check("sync_period", 32'(n), 4);
    check("sync_same2", 32'(LEDR == LEDG), 1);

    // Back to alternate; restart clears the phase.
    rx(8'h02); rx(8'h42);
    idle(1);
    check("alt_restart_ledr", 32'(LEDR), 0);
    check("alt_restart_ledg", 32'(LEDG), 1);
    wait_toggle(n);
    check("alt_toggle_seen", 32'(n != 0), 1);
    check("alt_opposite", 32'(LEDR != LEDG), 1);
    wait_toggle(n);
    check("alt_period", 32'(n), 4);

    // Pointer wrap and dropped reg0 write.
    rx(8'h3F); rx(8'h55); rx(8'h6A);
    rd(8'h55);
    rx(8'h3F);
    rd(8'h40);
    check("pre_err_err", 32'(err), 0);

    // Data byte first in a transaction: error, bytes ignored until STOP.
    stop();
    rx(8'h45);
    rx(8'h05); rx(8'h4F);
    idle(1);
    check("err_set", 32'(err), 1);
    stop();
    rx(8'h05); rd(8'h40);
    rx(8'h05); rx(8'h47);
    rx(8'h05); rd(8'h47);
    check("err_sticky", 32'(err), 1);

    // Four back-to-back reads from ptr 0.
    rx(8'h00);
    rd(8'h6A); rd(8'h55); rd(8'h42); rd(8'h40);

    // Simultaneous write and read at ptr 4.
    rx_rd(8'h44, 8'h44);
    idle(3);

    // Reset mid-stream: nothing may complete.
    GSRn = 1'b0;
    step(1'b1, 8'h4F, 1'b0, 1'b1);
    idle(1);
    GSRn = 1'b1;
    idle(2);
    check("mid_rst_err", 32'(err), 0);
    check("mid_rst_tx_byte", 32'(pif.tx_byte), 0);
    check("mid_rst_ledr", 32'(LEDR), 0);
    check("mid_rst_ledg", 32'(LEDG), 1);

    // Second read while one is pending is dropped and flags err.
    rx(8'h02);
    rx_rd(8'h80, 8'h42);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    idle(2);
    check("drop_err", 32'(err), 1);
    rd(8'h53);
    rd(8'h40);
    idle(4);

    check("sb_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pif_reg_seq.md
PIF_REG_SEQ -- requirements
Module: pif_reg_seq

Interface
REQ-001 Parameter PRESCALE, default 1000, clocks per blink-tick (min 2).
REQ-002 Parameter ID_VALUE, default 6'h2A, contents of read-only register 0.
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 GSRn  in  1  reset, synchronous and active-low.
REQ-005 rx_valid  in  1  one-cycle strobe: rx_byte holds a byte received from the I2C slave core.
REQ-006 rx_byte  in  8  received byte; [7:6] tag, [5:0] payload (I2C_DATA_BITS = 6).
REQ-007 rx_stop  in  1  one-cycle strobe: I2C STOP or repeated START seen.
REQ-008 tx_req  in  1  one-cycle strobe: the I2C core needs the next read byte.
REQ-009 tx_valid  out  1  one-cycle strobe: tx_byte is valid.
REQ-010 tx_byte  out  8  read byte, always {TAG_DATA, register value}.
REQ-011 err  out  1  sticky protocol-error flag.
REQ-012 LEDR, LEDG  out  1 each  LED drives, active high.

Function
REQ-013 Tags: TAG_ADDR=2'b00 loads the pointer; TAG_DATA=2'b01 writes a register; 2'b10 and 2'b11 are NOP; all tags are consumed.
REQ-014 Register file: 8 x 6 bit, addresses 0..7 decoded from ptr[2:0] when ptr[5:3]==0; addresses 8..63 ignore writes and read 6'h00.
REQ-015 Reg0 ID is read-only (ID_VALUE); reg1 scratch; reg2 LED control (bit0 1=sync/0=alternate, bit1 enable); reg3 blink half-period N; reg4..7 general RW.
REQ-016 FSM states: IDLE, ACTIVE, ERROR.
REQ-017 IDLE: TAG_ADDR -> load ptr, go ACTIVE; TAG_DATA -> set err, go ERROR, no write; NOP -> stay IDLE.
REQ-018 ACTIVE: TAG_ADDR reloads ptr; TAG_DATA writes reg[ptr] in the same cycle, then ptr=ptr+1 mod 64 (63 wraps to 0).
REQ-019 ERROR: all rx bytes are ignored.
REQ-020 rx_stop returns any state to IDLE the next cycle; ptr is retained across transactions.
REQ-021 tx_req: tx_valid is asserted exactly one cycle later with tx_byte={2'b01, reg[ptr]}; ptr increments mod 64; state is unchanged.
REQ-022 A write to reg0 is silently dropped; ptr still increments.
REQ-023 rx_valid and tx_req in the same cycle: rx is processed first; the read is held pending and served the cycle after, returning reg[ptr] as updated by the rx.
REQ-024 rx_stop and rx_valid in the same cycle: the byte is processed, then the FSM enters IDLE.
REQ-025 Only one read can be pending; a tx_req that arrives while one is pending is dropped and sets err.
REQ-026 Blink: a prescaler counts 0..PRESCALE-1 and pulses a tick at wrap; a half-period counter toggles phase after reg3+1 ticks.
REQ-027 LED outputs: bit1=0 -> LEDR=LEDG=0; alternate -> LEDR=phase, LEDG=~phase; sync -> LEDR=LEDG=phase.
REQ-028 A write to reg2 or reg3 clears the prescaler, half-period counter and phase on the next cycle.
REQ-029 err clears only on reset.

Reset
REQ-030 On clk rising with GSRn=0: state=IDLE, ptr=0, reg1=0, reg2=6'h02, reg3=6'd19, reg4..7=0.
REQ-031 Reset values, continued: err=0, tx_valid=0, tx_byte=0, pending=0, all counters=0, phase=0.
REQ-032 Reset mid-transaction aborts it; no partial write or read completes.

Structure
REQ-033 pifdefs package holds TAG_ADDR, TAG_DATA, I2C_DATA_BITS, register addresses, reset values and FSM state encoding.
REQ-034 One sub-module, pif_blink, contains the prescaler, half-period counter and LED muxing, fed by reg2/reg3 and a restart strobe.

Verification
REQ-035 Reset, then rx 8'h02, 8'h41, stop -> reg2=6'h01, err=0, LEDs disabled at 0/0.
REQ-036 PRESCALE=4, rx 8'h02, 8'h43, 8'h40 (reg3=0) -> LEDR=LEDG, toggling every 4 clocks; rewrite reg2=6'h02 -> LEDR=~LEDG.
REQ-037 rx 8'h3F, 8'h55, 8'h6A -> no reg change, last write lands at reg0 and is dropped, ptr=1; then tx_req -> tx_byte=8'h6A... no: tx_byte=8'h40|reg1.
REQ-038 Fresh transaction starting with 8'h45 -> err=1, FSM in ERROR, reg5 unchanged; after rx_stop, 8'h05, 8'h47 -> reg5=6'h07.
REQ-039 ptr=0, four tx_req -> tx_bytes 8'h6A, 8'h40|reg1, 8'h40|reg2, 8'h40|reg3, each one cycle after its request, ptr=4.
REQ-040 rx 8'h44 and tx_req in the same cycle with ptr=4 -> reg4=6'h04, tx_byte=8'h44 two cycles later; GSRn low mid-stream -> all reset values.
